// File: rtl/spi_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_arb_pkg
// Shared types and constants for the SPI RAM arbiter:
//   - state_t      : sequencer FSM states
//   - CMD_*        : 2-bit RAM command codes placed in ram_din[9:8]
//   - CMD_W/ADDR_W/DATA_W : command word and address/data widths
//   - make_cmd()   : packs a command code and payload into a RAM command word
// -----------------------------------------------------------------------------
package spi_ram_arb_pkg;

  localparam int CMD_W      = 10;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int NUM_PORTS  = 2;
  localparam int RD_TIMEOUT_DEFAULT = 15;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    WAIT_RD = 3'd3,
    RESP    = 3'd4
  } state_t;

  function automatic logic [CMD_W-1:0] make_cmd(input logic [1:0]        code,
                                                input logic [DATA_W-1:0] payload);
    return {code, payload};
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational owner selection for the two-port RAM arbiter.
//   i_req        : pending requests, bit n = port n
//   i_last_grant : (RR_ARB_EN only) port granted most recently, 0 or 1
//   o_winner     : one-hot winning port, 0 when nothing is pending
// Macro RR_ARB_EN: defined -> round-robin on a tie (the port not granted last
// wins); undefined -> fixed priority, port 0 always wins a tie.
// -----------------------------------------------------------------------------
module arb_pick
  import spi_ram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
`ifdef RR_ARB_EN
  input  logic                 i_last_grant,
`endif
  output logic [NUM_PORTS-1:0] o_winner
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    o_winner = '0;
    if (i_req == 2'b11) begin
`ifdef RR_ARB_EN
      o_winner = i_last_grant ? 2'b01 : 2'b10;
`else
      o_winner = 2'b01;
`endif
    end else begin
      // Zero or one request pending: the request vector is already one-hot.
      o_winner = i_req;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// spi_ram_arbiter
// Two-requester sequencer/arbiter for the single-port RAM behind the SPI slave.
// A granted word request is expanded into an address command followed by a
// data command on ram_din; reads then wait for ram_tx_valid (or time out).
// Port 0 is the SPI-side requester, port 1 the local host/debug port.
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   pN_req/we/addr/wdata    request from port N, held until pN_ack
//   pN_ack/rdata/err        one-cycle completion, read data, read timeout
//   ram_din, ram_rx_valid   RAM command word {cmd[1:0], payload[7:0]} + strobe
//   ram_dout, ram_tx_valid  RAM read data + strobe
//   grant                   one-hot owner of the current transaction
//
// Parameter RD_TIMEOUT: cycles in WAIT_RD without ram_tx_valid before a read
// completes with err = 1.
// Macro RR_ARB_EN: defined -> round-robin tie-break with a last-grant pointer;
// undefined -> fixed priority to port 0.
// -----------------------------------------------------------------------------
module spi_ram_arbiter
  import spi_ram_arb_pkg::*;
#(
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,

  output logic [CMD_W-1:0]  ram_din,
  output logic              ram_rx_valid,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_tx_valid,

  output logic [1:0]        grant
);

  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

  state_t              r_state;
  logic [1:0]          r_grant;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [TMO_W-1:0]    r_tmo_cnt;

  logic [CMD_W-1:0]    r_ram_din;
  logic                r_ram_rx_valid;
  logic                r_p0_ack;
  logic                r_p1_ack;
  logic [DATA_W-1:0]   r_p0_rdata;
  logic [DATA_W-1:0]   r_p1_rdata;
  logic                r_p0_err;
  logic                r_p1_err;

  logic [1:0]          w_winner;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [TMO_W-1:0]    w_tmo_next;
  logic                w_tmo_hit;
  logic                w_rd_done;
  logic [DATA_W-1:0]   w_rd_value;

`ifdef RR_ARB_EN
  // Port granted most recently; resets to port 1 so port 0 wins the first tie.
  logic                r_last_grant;

  arb_pick u_arb_pick (
    .i_req        ({p1_req, p0_req}),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner)
  );
`else
  arb_pick u_arb_pick (
    .i_req    ({p1_req, p0_req}),
    .o_winner (w_winner)
  );
`endif

  // Request fields of the winning port; only consumed in IDLE.
  assign w_sel_we    = w_winner[1] ? p1_we    : p0_we;
  assign w_sel_addr  = w_winner[1] ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_winner[1] ? p1_wdata : p0_wdata;

  // The counter holds the number of WAIT_RD cycles already spent; the read is
  // errored on the edge where that count would reach RD_TIMEOUT.
  assign w_tmo_next = r_tmo_cnt + TMO_W'(1);
  assign w_tmo_hit  = (w_tmo_next == TMO_W'(RD_TIMEOUT));

  // RAM data wins over a timeout landing in the same cycle.
  assign w_rd_done  = ram_tx_valid | w_tmo_hit;
  assign w_rd_value = ram_tx_valid ? ram_dout : '0;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_grant        <= '0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_tmo_cnt      <= '0;
      r_ram_din      <= '0;
      r_ram_rx_valid <= 1'b0;
      r_p0_ack       <= 1'b0;
      r_p1_ack       <= 1'b0;
      r_p0_rdata     <= '0;
      r_p1_rdata     <= '0;
      r_p0_err       <= 1'b0;
      r_p1_err       <= 1'b0;
`ifdef RR_ARB_EN
      r_last_grant   <= 1'b1;
`endif
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      r_ram_rx_valid <= 1'b0;
      r_p0_ack       <= 1'b0;
      r_p1_ack       <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (|w_winner) begin
            r_grant        <= w_winner;
            r_we           <= w_sel_we;
            r_addr         <= w_sel_addr;
            r_wdata        <= w_sel_wdata;
            r_ram_rx_valid <= 1'b1;
            r_ram_din      <= make_cmd(w_sel_we ? CMD_WR_ADDR : CMD_RD_ADDR, w_sel_addr);
            r_state        <= ADDR;
`ifdef RR_ARB_EN
            r_last_grant   <= w_winner[1];
`endif
          end
        end

        ADDR: begin
          // Address was on the bus this cycle; present the data command next.
          r_ram_rx_valid <= 1'b1;
          r_ram_din      <= r_we ? make_cmd(CMD_WR_DATA, r_wdata)
                                 : make_cmd(CMD_RD_DATA, '0);
          r_state        <= DATA;
        end

        DATA: begin
          if (r_we) begin
            // Writes complete without a RAM response; rdata keeps its value.
            if (r_grant[0]) begin
              r_p0_ack <= 1'b1;
              r_p0_err <= 1'b0;
            end else begin
              r_p1_ack <= 1'b1;
              r_p1_err <= 1'b0;
            end
            r_state <= RESP;
          end else begin
            r_tmo_cnt <= '0;
            r_state   <= WAIT_RD;
          end
        end

        WAIT_RD: begin
          r_tmo_cnt <= w_tmo_next;
          if (w_rd_done) begin
            if (r_grant[0]) begin
              r_p0_ack   <= 1'b1;
              r_p0_rdata <= w_rd_value;
              r_p0_err   <= ~ram_tx_valid;
            end else begin
              r_p1_ack   <= 1'b1;
              r_p1_rdata <= w_rd_value;
              r_p1_err   <= ~ram_tx_valid;
            end
            r_state <= RESP;
          end
        end

        RESP: begin
          // Ack is high during this cycle; release ownership on the way out.
          r_grant <= '0;
          r_state <= IDLE;
        end

        default: begin
          r_grant <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ram_din      = r_ram_din;
  assign ram_rx_valid = r_ram_rx_valid;
  assign grant        = r_grant;
  assign p0_ack       = r_p0_ack;
  assign p1_ack       = r_p1_ack;
  assign p0_rdata     = r_p0_rdata;
  assign p1_rdata     = r_p1_rdata;
  assign p0_err       = r_p0_err;
  assign p1_err       = r_p1_err;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_arbiter
// Directed bench for spi_ram_arbiter. Stimulus pushes expected RAM commands,
// grants and acks into queues; a negedge monitor pops and compares them
// whenever the DUT presents ram_rx_valid, a new grant, or an ack.
// A small RAM model answers read-data commands one cycle later.
// -----------------------------------------------------------------------------
module tb_spi_ram_arbiter;

  localparam int ACK_BOUND = 60;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        p0_req, p0_we, p1_req, p1_we;
  logic [7:0]  p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack, p0_err, p1_err;
  logic [7:0]  p0_rdata, p1_rdata;
  logic [9:0]  ram_din;
  logic        ram_rx_valid;
  logic [7:0]  ram_dout;
  logic        ram_tx_valid;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  spi_ram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_req       (p0_req),
    .p0_we        (p0_we),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_ack       (p0_ack),
    .p0_rdata     (p0_rdata),
    .p0_err       (p0_err),
    .p1_req       (p1_req),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_ack       (p1_ack),
    .p1_rdata     (p1_rdata),
    .p1_err       (p1_err),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .grant        (grant)
  );

  // ---------------------------------------------------------------- counters
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------- RAM model
  logic [7:0] mem [256];
  logic [7:0] m_addr      = 8'h00;
  logic       model_valid = 1'b0;
  logic [7:0] model_dout  = 8'h00;
  logic       model_en;
  logic       stray_valid;
  logic [7:0] stray_dout;

  assign ram_tx_valid = model_valid | stray_valid;
  assign ram_dout     = stray_valid ? stray_dout : model_dout;

  always @(posedge clk) begin
    model_valid <= 1'b0;
    if (ram_rx_valid === 1'b1) begin
      case (ram_din[9:8])
        2'b00, 2'b10: m_addr <= ram_din[7:0];
        2'b01:        mem[m_addr] <= ram_din[7:0];
        default: begin
          if (model_en) begin
            model_valid <= 1'b1;
            model_dout  <= mem[m_addr];
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------- scoreboard
  typedef struct {
    logic [9:0] din;
    int         cyc;
  } cmd_exp_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    bit         chk_rdata;
    int         cyc;
  } ack_exp_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } op_t;

  cmd_exp_t   cmd_q[$];
  ack_exp_t   ack_q0[$];
  ack_exp_t   ack_q1[$];
  logic [1:0] grant_q[$];
  op_t        ops0[$];
  op_t        ops1[$];

  task automatic exp_cmd(input logic [9:0] din, input int c);
    cmd_exp_t e;
    e.din = din;
    e.cyc = c;
    cmd_q.push_back(e);
  endtask

  task automatic exp_ack(input int port, input logic [7:0] rdata, input logic err,
                         input bit chk_rdata, input int c);
    ack_exp_t e;
    e.rdata     = rdata;
    e.err       = err;
    e.chk_rdata = chk_rdata;
    e.cyc       = c;
    if (port == 0) ack_q0.push_back(e);
    else           ack_q1.push_back(e);
  endtask

  task automatic add_op(input int port, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata);
    op_t o;
    o.we    = we;
    o.addr  = addr;
    o.wdata = wdata;
    if (port == 0) ops0.push_back(o);
    else           ops1.push_back(o);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  logic [1:0] prev_grant = 2'b00;
  cmd_exp_t   mon_cmd;
  ack_exp_t   mon_ack;

  always @(negedge clk) begin
    if (ram_rx_valid === 1'b1) begin
      if (cmd_q.size() == 0) begin
        check("cmd_unexpected_rx_valid", ram_rx_valid, 0);
      end else begin
        mon_cmd = cmd_q.pop_front();
        check("ram_din", ram_din, mon_cmd.din);
        if (mon_cmd.cyc >= 0) check("cmd_cycle", cyc, mon_cmd.cyc);
      end
    end

    if (grant !== 2'b00 && grant !== 2'bxx && prev_grant === 2'b00) begin
      if (grant_q.size() == 0) check("grant_unexpected", grant, 0);
      else                     check("grant_order", grant, grant_q.pop_front());
    end
    prev_grant <= grant;

    if (p0_ack === 1'b1) begin
      if (ack_q0.size() == 0) begin
        check("p0_ack_unexpected", p0_ack, 0);
      end else begin
        mon_ack = ack_q0.pop_front();
        check("p0_err", p0_err, mon_ack.err);
        if (mon_ack.chk_rdata) check("p0_rdata", p0_rdata, mon_ack.rdata);
        if (mon_ack.cyc >= 0)  check("p0_ack_cycle", cyc, mon_ack.cyc);
      end
    end

    if (p1_ack === 1'b1) begin
      if (ack_q1.size() == 0) begin
        check("p1_ack_unexpected", p1_ack, 0);
      end else begin
        mon_ack = ack_q1.pop_front();
        check("p1_err", p1_err, mon_ack.err);
        if (mon_ack.chk_rdata) check("p1_rdata", p1_rdata, mon_ack.rdata);
        if (mon_ack.cyc >= 0)  check("p1_ack_cycle", cyc, mon_ack.cyc);
      end
    end
  end

  // ------------------------------------------------------------------ driver
  // Must be called at a negedge. Holds req high across queued ops, moving to
  // the next op's fields in the ack cycle, and drops req after the last ack.
  task automatic run_port(input int port);
    op_t  op;
    int   waited;
    logic got;
    forever begin
      if (port == 0) begin
        if (ops0.size() == 0) break;
        op       = ops0.pop_front();
        p0_we    = op.we;
        p0_addr  = op.addr;
        p0_wdata = op.wdata;
        p0_req   = 1'b1;
      end else begin
        if (ops1.size() == 0) break;
        op       = ops1.pop_front();
        p1_we    = op.we;
        p1_addr  = op.addr;
        p1_wdata = op.wdata;
        p1_req   = 1'b1;
      end
      waited = 0;
      got    = 1'b0;
      while (!got && waited < ACK_BOUND) begin
        @(negedge clk);
        waited++;
        got = (port == 0) ? p0_ack : p1_ack;
      end
      if (got !== 1'b1) begin
        check((port == 0) ? "p0_ack_within_bound" : "p1_ack_within_bound", got, 1);
        break;
      end
    end
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  int c;
  int order [8];
  int idx0, idx1;

  initial begin
    rst_n       = 1'b0;
    p0_req      = 1'b0; p0_we = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
    p1_req      = 1'b0; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
    model_en    = 1'b1;
    stray_valid = 1'b0;
    stray_dout  = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_grant",        grant,        0);
    check("rst_ram_rx_valid", ram_rx_valid, 0);
    check("rst_ram_din",      ram_din,      0);
    check("rst_p0_ack",       p0_ack,       0);
    check("rst_p1_ack",       p1_ack,       0);
    check("rst_p0_rdata",     p0_rdata,     0);
    check("rst_p1_rdata",     p1_rdata,     0);
    check("rst_p0_err",       p0_err,       0);
    check("rst_p1_err",       p1_err,       0);
    rst_n = 1'b1;
    @(negedge clk);

    // Port 0 write 3C <- A5: commands in T+1/T+2, ack in T+3.
    c = cyc;
    exp_cmd(10'h03C, c + 1);
    exp_cmd(10'h1A5, c + 2);
    grant_q.push_back(2'b01);
    exp_ack(0, 8'h00, 1'b0, 1'b0, c + 3);
    add_op(0, 1'b1, 8'h3C, 8'hA5);
    run_port(0);
    repeat (2) @(negedge clk);

    // Port 1 read 3C: RAM answers one cycle after the read-data command.
    c = cyc;
    exp_cmd(10'h23C, c + 1);
    exp_cmd(10'h300, c + 2);
    grant_q.push_back(2'b10);
    exp_ack(1, 8'hA5, 1'b0, 1'b1, c + 4);
    add_op(1, 1'b0, 8'h3C, 8'h00);
    run_port(1);
    repeat (2) @(negedge clk);

    // Both ports hold four writes each, all presented in the same IDLE cycle.
`ifdef RR_ARB_EN
    order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    idx0 = 0;
    idx1 = 0;
    for (int k = 0; k < 8; k++) begin
      if (order[k] == 0) begin
        exp_cmd({2'b00, 8'h10 + 8'(idx0)}, -1);
        exp_cmd({2'b01, 8'h50 + 8'(idx0)}, -1);
        grant_q.push_back(2'b01);
        exp_ack(0, 8'h00, 1'b0, 1'b0, -1);
        idx0++;
      end else begin
        exp_cmd({2'b00, 8'h20 + 8'(idx1)}, -1);
        exp_cmd({2'b01, 8'h60 + 8'(idx1)}, -1);
        grant_q.push_back(2'b10);
        exp_ack(1, 8'h00, 1'b0, 1'b0, -1);
        idx1++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      add_op(0, 1'b1, 8'h10 + 8'(i), 8'h50 + 8'(i));
      add_op(1, 1'b1, 8'h20 + 8'(i), 8'h60 + 8'(i));
    end
    fork
      run_port(0);
      run_port(1);
    join
    repeat (2) @(negedge clk);

    // Simultaneous reads: port 0 wins in both arbitration modes here.
    exp_cmd(10'h212, -1);
    exp_cmd(10'h300, -1);
    exp_cmd(10'h221, -1);
    exp_cmd(10'h300, -1);
    grant_q.push_back(2'b01);
    grant_q.push_back(2'b10);
    exp_ack(0, 8'h52, 1'b0, 1'b1, -1);
    exp_ack(1, 8'h61, 1'b0, 1'b1, -1);
    add_op(0, 1'b0, 8'h12, 8'h00);
    add_op(1, 1'b0, 8'h21, 8'h00);
    fork
      run_port(0);
      run_port(1);
    join
    repeat (2) @(negedge clk);

    // Read timeout: RAM silent, ack 16 cycles after DATA with rdata 0, err 1.
    model_en = 1'b0;
    c = cyc;
    exp_cmd(10'h255, c + 1);
    exp_cmd(10'h300, c + 2);
    grant_q.push_back(2'b01);
    exp_ack(0, 8'h00, 1'b1, 1'b1, c + 18);
    add_op(0, 1'b0, 8'h55, 8'h00);
    run_port(0);
    @(negedge clk);
    check("tmo_idle_grant",        grant,        0);
    check("tmo_idle_ram_rx_valid", ram_rx_valid, 0);
    model_en = 1'b1;
    @(negedge clk);

    // Reset during the DATA cycle of a port 0 write: abandoned, no ack.
    c = cyc;
    exp_cmd(10'h03C, c + 1);
    exp_cmd(10'h1FF, c + 2);
    grant_q.push_back(2'b01);
    p0_we    = 1'b1;
    p0_addr  = 8'h3C;
    p0_wdata = 8'hFF;
    p0_req   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_in_data", ram_din, 10'h1FF);
    rst_n  = 1'b0;
    p0_req = 1'b0;
    @(negedge clk);
    check("mid_rst_ram_rx_valid", ram_rx_valid, 0);
    check("mid_rst_grant",        grant,        0);
    check("mid_rst_ram_din",      ram_din,      0);
    check("mid_rst_p0_ack",       p0_ack,       0);
    check("mid_rst_p0_err",       p0_err,       0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    c = cyc;
    exp_cmd(10'h213, c + 1);
    exp_cmd(10'h300, c + 2);
    grant_q.push_back(2'b10);
    exp_ack(1, 8'h53, 1'b0, 1'b1, c + 4);
    add_op(1, 1'b0, 8'h13, 8'h00);
    run_port(1);
    repeat (2) @(negedge clk);

    // Stray ram_tx_valid in IDLE.
    stray_dout  = 8'hEE;
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_idle_p0_rdata", p0_rdata, 8'h00);
    check("stray_idle_p1_rdata", p1_rdata, 8'h53);

    // Stray ram_tx_valid while a port 0 write sits in ADDR.
    c = cyc;
    exp_cmd(10'h070, c + 1);
    exp_cmd(10'h111, c + 2);
    grant_q.push_back(2'b01);
    exp_ack(0, 8'h00, 1'b0, 1'b0, c + 3);
    add_op(0, 1'b1, 8'h70, 8'h11);
    fork
      run_port(0);
      begin
        @(negedge clk);
        stray_dout  = 8'hEE;
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("stray_wr_p0_rdata", p0_rdata, 8'h00);
    check("stray_wr_p1_rdata", p1_rdata, 8'h53);

    // Everything expected must have been seen.
    check("cmd_q_drained",   cmd_q.size(),   0);
    check("grant_q_drained", grant_q.size(), 0);
    check("ack_q0_drained",  ack_q0.size(),  0);
    check("ack_q1_drained",  ack_q1.size(),  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
